// File: rtl/instr_decoder_pkg.sv
// Shared types and link constants for the instruction decoder.
// Frame delimiters default here unless INSTR_HEAD/INSTR_TAIL are predefined.
`ifndef INSTR_HEAD
`define INSTR_HEAD 32'hA5A5_5A5A
`endif
`ifndef INSTR_TAIL
`define INSTR_TAIL 32'h5A5A_A5A5
`endif

package instr_decoder_pkg;

  localparam logic [31:0] HEAD_WORD = `INSTR_HEAD;
  localparam logic [31:0] TAIL_WORD = `INSTR_TAIL;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_INSTR = 2'd1,
    ST_TAIL  = 2'd2,
    ST_CHECK = 2'd3
  } state_t;

endpackage

// File: rtl/instr_gap_timer.sv
// Intra-frame idle gap timer for the instruction decoder.
// expire is combinational: high on the TIMEOUT-th idle cycle.
module instr_gap_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic kick,
  output logic expire
);

  if (TIMEOUT == 0) begin : g_off
    assign expire = 1'b0;
  end else begin : g_on
    localparam int GW = $clog2(TIMEOUT + 1);
    localparam logic [GW-1:0] LAST = GW'(TIMEOUT - 1);

    logic [GW-1:0] gap;

    assign expire = run && !kick && (gap == LAST);

    // count idle cycles while a frame is open
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        gap <= '0;
      end else if (!run || kick || expire) begin
        gap <= '0;
      end else begin
        gap <= gap + 1'b1;
      end
    end
  end

endmodule

// File: rtl/instr_decoder.sv
// Frame hunter/validator delivering INSTR words over valid/ready.
// Optional stats counters: define INSTR_DECODER_STAT_EN.
import instr_decoder_pkg::*;

module instr_decoder #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  sys_clk,
  input  logic                  sys_rstn,
  input  logic                  pre_en,
  input  logic [DATA_WIDTH-1:0] pre_data,
  input  logic                  post_ready,
  output logic                  post_en,
  output logic [DATA_WIDTH-1:0] post_data,
  output logic                  err_tail,
  output logic                  err_sum,
  output logic                  err_timeout,
  output logic                  err_ovf
`ifdef INSTR_DECODER_STAT_EN
  ,
  output logic [15:0]           frame_cnt,
  output logic [15:0]           err_cnt
`endif
);

  localparam logic [DATA_WIDTH-1:0] HEAD =
    DATA_WIDTH'(HEAD_WORD);
  localparam logic [DATA_WIDTH-1:0] TAIL =
    DATA_WIDTH'(TAIL_WORD);

  state_t                  state, state_n;
  logic [DATA_WIDTH-1:0]   sum, sum_n;
  logic [DATA_WIDTH-1:0]   instr_r, instr_n;
  logic                    tail_n, chk_n, good;
  logic                    expire, load, ovf_n;

  instr_gap_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_gap (
    .clk    (sys_clk),
    .rst_n  (sys_rstn),
    .run    (state != ST_IDLE),
    .kick   (pre_en),
    .expire (expire)
  );

  assign load  = good && (!post_en || post_ready);
  assign ovf_n = good && post_en && !post_ready;

  // state register
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // frame parsing: next state, checksum and error detection
  always_comb begin
    state_n = state;
    sum_n   = sum;
    instr_n = instr_r;
    tail_n  = 1'b0;
    chk_n   = 1'b0;
    good    = 1'b0;
    if (expire) begin
      state_n = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (pre_en && pre_data == HEAD) begin
            state_n = ST_INSTR;
            sum_n   = HEAD;
          end
        end
        ST_INSTR: begin
          if (pre_en) begin
            instr_n = pre_data;
            sum_n   = sum + pre_data;
            state_n = ST_TAIL;
          end
        end
        ST_TAIL: begin
          if (pre_en) begin
            if (pre_data == TAIL) begin
              sum_n   = sum + TAIL;
              state_n = ST_CHECK;
            end else begin
              tail_n = 1'b1;
              if (pre_data == HEAD) begin
                sum_n   = HEAD;
                state_n = ST_INSTR;
              end else begin
                state_n = ST_IDLE;
              end
            end
          end
        end
        ST_CHECK: begin
          if (pre_en) begin
            state_n = ST_IDLE;
            if (pre_data == ~sum) begin
              good = 1'b1;
            end else begin
              chk_n = 1'b1;
            end
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // checksum accumulator and captured instruction
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      sum     <= '0;
      instr_r <= '0;
    end else begin
      sum     <= sum_n;
      instr_r <= instr_n;
    end
  end

  // holding register toward the dispatcher
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      post_en   <= 1'b0;
      post_data <= '0;
    end else if (load) begin
      post_en   <= 1'b1;
      post_data <= instr_r;
    end else if (post_ready) begin
      post_en   <= 1'b0;
    end
  end

  // one-cycle error pulses
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      err_tail    <= 1'b0;
      err_sum     <= 1'b0;
      err_timeout <= 1'b0;
      err_ovf     <= 1'b0;
    end else begin
      err_tail    <= tail_n;
      err_sum     <= chk_n;
      err_timeout <= expire;
      err_ovf     <= ovf_n;
    end
  end

`ifdef INSTR_DECODER_STAT_EN
  logic [2:0]  err_inc;
  logic [16:0] err_add;

  assign err_inc = {2'b0, tail_n} + {2'b0, chk_n}
                 + {2'b0, expire} + {2'b0, ovf_n};
  assign err_add = {1'b0, err_cnt} + 17'(err_inc);

  // saturating frame and error statistics
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      if (load && frame_cnt != 16'hFFFF) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
      err_cnt <= err_add[16] ? 16'hFFFF : err_add[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_instr_decoder.sv
// Directed table-driven bench for instr_decoder.
// Build with +define+INSTR_DECODER_STAT_EN to also check counters.
import instr_decoder_pkg::*;

module tb_instr_decoder;

  localparam logic [31:0] H  = 32'hA5A5_5A5A;
  localparam logic [31:0] T  = 32'h5A5A_A5A5;
  localparam logic [31:0] C1 = 32'hFFFF_EDCC;
  localparam logic [31:0] C5 = 32'hFFFF_A988;
  localparam logic [31:0] C9 = 32'hFFFF_6544;
  localparam logic [3:0]  E_TAIL = 4'b0001;
  localparam logic [3:0]  E_SUM  = 4'b0010;
  localparam logic [3:0]  E_TO   = 4'b0100;
  localparam logic [3:0]  E_OVF  = 4'b1000;

  typedef struct {
    logic        en;
    logic [31:0] data;
    logic        rdy;
    logic        pe;
    logic [31:0] pd;
    logic [3:0]  err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        pre_en = 1'b0;
  logic [31:0] pre_data = '0;
  logic        post_ready = 1'b0;
  logic        post_en;
  logic [31:0] post_data;
  logic        err_tail, err_sum, err_timeout, err_ovf;
`ifdef INSTR_DECODER_STAT_EN
  logic [15:0] frame_cnt, err_cnt;
`endif

  int checks = 0;
  int errors = 0;
  vec_t vq[$];

  instr_decoder #(
    .DATA_WIDTH (32),
    .TIMEOUT    (16)
  ) dut (
    .sys_clk     (clk),
    .sys_rstn    (rstn),
    .pre_en      (pre_en),
    .pre_data    (pre_data),
    .post_ready  (post_ready),
    .post_en     (post_en),
    .post_data   (post_data),
    .err_tail    (err_tail),
    .err_sum     (err_sum),
    .err_timeout (err_timeout),
    .err_ovf     (err_ovf)
`ifdef INSTR_DECODER_STAT_EN
    ,
    .frame_cnt   (frame_cnt),
    .err_cnt     (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic en, input logic [31:0] d,
                     input logic rdy, input logic pe,
                     input logic [31:0] pd, input logic [3:0] e);
    vec_t v;
    v.en = en; v.data = d; v.rdy = rdy;
    v.pe = pe; v.pd = pd; v.err = e;
    vq.push_back(v);
  endtask

  task automatic idle(input int n, input logic rdy,
                      input logic pe, input logic [31:0] pd);
    for (int k = 0; k < n; k++) add(0, 32'h0, rdy, pe, pd, 4'h0);
  endtask

  task automatic apply(input vec_t v, input string tag);
    pre_en     = v.en;
    pre_data   = v.data;
    post_ready = v.rdy;
    @(posedge clk);
    #1;
    chk({tag, " post_en"}, {31'b0, post_en}, {31'b0, v.pe});
    chk({tag, " post_data"}, post_data, v.pd);
    chk({tag, " err"},
        {28'b0, err_ovf, err_timeout, err_sum, err_tail},
        {28'b0, v.err});
  endtask

  initial begin
    vec_t v;

    // junk before a head is dropped
    add(1, 32'hDEAD_BEEF, 1, 0, 32'h0, 4'h0);
    add(1, T,             1, 0, 32'h0, 4'h0);
    // good frame
    add(1, H,      1, 0, 32'h0, 4'h0);
    add(1, 32'h1234, 1, 0, 32'h0, 4'h0);
    add(1, T,      1, 0, 32'h0, 4'h0);
    add(1, C1,     1, 1, 32'h1234, 4'h0);
    idle(1, 1, 0, 32'h1234);
    // bad checksum
    add(1, H,        1, 0, 32'h1234, 4'h0);
    add(1, 32'h1234, 1, 0, 32'h1234, 4'h0);
    add(1, T,        1, 0, 32'h1234, 4'h0);
    add(1, C1 ^ 32'h1, 1, 0, 32'h1234, E_SUM);
    idle(1, 1, 0, 32'h1234);
    // head in tail slot resyncs
    add(1, H,        1, 0, 32'h1234, 4'h0);
    add(1, 32'h1234, 1, 0, 32'h1234, 4'h0);
    add(1, H,        1, 0, 32'h1234, E_TAIL);
    add(1, 32'h5678, 1, 0, 32'h1234, 4'h0);
    add(1, T,        1, 0, 32'h1234, 4'h0);
    add(1, C5,       1, 1, 32'h5678, 4'h0);
    idle(1, 1, 0, 32'h5678);
    // other word in tail slot drops to idle
    add(1, H,        1, 0, 32'h5678, 4'h0);
    add(1, 32'h1234, 1, 0, 32'h5678, 4'h0);
    add(1, 32'h0,    1, 0, 32'h5678, E_TAIL);
    add(1, 32'h1234, 1, 0, 32'h5678, 4'h0);
    // 15 idle cycles survive
    add(1, H,        1, 0, 32'h5678, 4'h0);
    add(1, 32'h1234, 1, 0, 32'h5678, 4'h0);
    idle(15, 1, 0, 32'h5678);
    add(1, T,        1, 0, 32'h5678, 4'h0);
    add(1, C1,       1, 1, 32'h1234, 4'h0);
    idle(1, 1, 0, 32'h1234);
    // 16 idle cycles time out
    add(1, H,        1, 0, 32'h1234, 4'h0);
    add(1, 32'h1234, 1, 0, 32'h1234, 4'h0);
    idle(15, 1, 0, 32'h1234);
    add(0, 32'h0,    1, 0, 32'h1234, E_TO);
    add(1, T,        1, 0, 32'h1234, 4'h0);
    add(1, C1,       1, 0, 32'h1234, 4'h0);
    // holding register full -> overflow
    add(1, H,        0, 0, 32'h1234, 4'h0);
    add(1, 32'h1234, 0, 0, 32'h1234, 4'h0);
    add(1, T,        0, 0, 32'h1234, 4'h0);
    add(1, C1,       0, 1, 32'h1234, 4'h0);
    add(1, H,        0, 1, 32'h1234, 4'h0);
    add(1, 32'h9ABC, 0, 1, 32'h1234, 4'h0);
    add(1, T,        0, 1, 32'h1234, 4'h0);
    add(1, C9,       0, 1, 32'h1234, E_OVF);
    idle(1, 0, 1, 32'h1234);
    // release and reload in the same cycle
    add(1, H,        0, 1, 32'h1234, 4'h0);
    add(1, 32'h5678, 0, 1, 32'h1234, 4'h0);
    add(1, T,        0, 1, 32'h1234, 4'h0);
    add(1, C5,       1, 1, 32'h5678, 4'h0);
    idle(1, 1, 0, 32'h5678);

    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset post_en", {31'b0, post_en}, 32'h0);
    chk("reset post_data", post_data, 32'h0);
    chk("reset err",
        {28'b0, err_ovf, err_timeout, err_sum, err_tail}, 32'h0);
    rstn = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      apply(vq[i], $sformatf("v%0d", i));
    end

    // async reset while in TAIL with a word held
    v = '{1, H, 0, 0, 32'h5678, 4'h0};        apply(v, "r0");
    v = '{1, 32'h1234, 0, 0, 32'h5678, 4'h0}; apply(v, "r1");
    v = '{1, T, 0, 0, 32'h5678, 4'h0};        apply(v, "r2");
    v = '{1, C1, 0, 1, 32'h1234, 4'h0};       apply(v, "r3");
    v = '{1, H, 0, 1, 32'h1234, 4'h0};        apply(v, "r4");
    v = '{1, 32'h1234, 0, 1, 32'h1234, 4'h0}; apply(v, "r5");
    pre_en = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    chk("async post_en", {31'b0, post_en}, 32'h0);
    chk("async post_data", post_data, 32'h0);
    @(posedge clk);
    #2;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    v = '{1, H, 1, 0, 32'h0, 4'h0};           apply(v, "p0");
    v = '{1, 32'h1234, 1, 0, 32'h0, 4'h0};    apply(v, "p1");
    v = '{1, T, 1, 0, 32'h0, 4'h0};           apply(v, "p2");
    v = '{1, C1, 1, 1, 32'h1234, 4'h0};       apply(v, "p3");
`ifdef INSTR_DECODER_STAT_EN
    chk("frame_cnt", {16'b0, frame_cnt}, 32'd1);
    chk("err_cnt", {16'b0, err_cnt}, 32'd0);
`endif
    v = '{0, 32'h0, 1, 0, 32'h1234, 4'h0};    apply(v, "p4");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
